pipe_stage_hs: RTL and testbench

Parametrised valid/ready pipeline stage register that replaces the fixed-field, stall/flush-driven inter-stage registers in the NPC pipeline. It carries an opaque payload split into a data field and a control field, and zeroes the control field whenever the slot is empty or flushed. An optional skid entry gives full throughput with a registered `in_ready`. It also keeps a saturating back-pressure counter for performance analysis.

---
 rtl/pipe_stage_hs.sv | 73 +++++++
 tb/tb_pipe_stage_hs.sv | 122 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline register with optional skid entry, control zeroing and stall counter
module pipe_stage_hs #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 16,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cycles
);
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              accept, pop, take_skid, load_main, load_skid;

    assign in_ready     = !rst && ((SKID != 0) ? in_ready_q : (!main_valid_q || out_ready));
    assign out_valid    = main_valid_q;
    assign out_data     = main_data_q;
    assign out_ctrl     = main_ctrl_q;
    assign occupancy    = {1'b0, main_valid_q} + {1'b0, skid_valid_q};
    assign stall_cycles = stall_q;

    // Next state: skid refills main on pop, otherwise a new beat lands in main or skid; flush empties both
    always_comb begin
        accept       = in_valid && in_ready;
        pop          = main_valid_q && out_ready;
        take_skid    = !flush && pop && skid_valid_q;
        load_main    = !flush && accept && (!main_valid_q || pop);
        load_skid    = !flush && accept && main_valid_q && !pop && (SKID != 0);
        main_valid_d = flush ? 1'b0 : (take_skid || load_main) ? 1'b1 : pop ? 1'b0 : main_valid_q;
        main_data_d  = take_skid ? skid_data_q : load_main ? in_data : main_data_q;
        main_ctrl_d  = !main_valid_d ? '0 : take_skid ? skid_ctrl_q : load_main ? in_ctrl : main_ctrl_q;
        skid_valid_d = flush ? 1'b0 : load_skid ? 1'b1 : take_skid ? 1'b0 : skid_valid_q;
        skid_data_d  = load_skid ? in_data : skid_data_q;
        skid_ctrl_d  = !skid_valid_d ? '0 : load_skid ? in_ctrl : skid_ctrl_q;
        stall_d      = (main_valid_q && !out_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    // State registers; in_ready is registered from the next skid state so it never depends on out_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
            in_ready_q   <= 1'b1;
            stall_q      <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
            in_ready_q   <= !skid_valid_d;
            stall_q      <= stall_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_hs.sv
// tb_pipe_stage_hs: queue-scoreboard bench for the skid and non-skid variants driven by shared stimulus
module tb_pipe_stage_hs;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic [15:0] in_ctrl = '0;
    logic [1:0]  rdy, ov;
    logic [31:0] od1, od0;
    logic [15:0] oc1, oc0;
    logic [1:0]  occ1, occ0;
    logic [3:0]  st1, st0;

    logic [47:0] q [2][$];
    logic [1:0]  exp_rdy = '0;
    logic [1:0]  stall_inc = '0;
    int          exp_st [2] = '{0, 0};
    bit          armed = 0;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(32), .CTRL_W(16), .SKID(1), .CNT_W(4)) u_skid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od1), .out_ctrl(oc1), .occupancy(occ1), .stall_cycles(st1));

    pipe_stage_hs #(.DATA_W(32), .CTRL_W(16), .SKID(0), .CNT_W(4)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od0), .out_ctrl(oc0), .occupancy(occ0), .stall_cycles(st0));

    task automatic chk(input int k, input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL skid%0d %s: got %0h expected %0h at %0t", k, n, a, e, $time);
    endtask

    task automatic cyc(input logic v, input logic [31:0] d, input logic [15:0] c, input logic r, input logic f);
        in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f;
        @(posedge clk);
        #1;
    endtask

    // Reference model: queue of beats per variant; accept uses the readiness the rules predict, flush/rst empty it
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) q[k].delete();
            else if (in_valid && exp_rdy[k]) q[k].push_back({in_data, in_ctrl});
            exp_st[k] = rst ? 0 : (stall_inc[k] && exp_st[k] != 15) ? exp_st[k] + 1 : exp_st[k];
        end
        if (rst) armed = 1;
    end

    // Monitor: compare outputs to the queue head each cycle, pop on a handshake
    always @(negedge clk) begin
        if (armed) begin
            for (int k = 0; k < 2; k++) begin
                int sz;
                logic [47:0] h;
                sz = q[k].size();
                h = (sz > 0) ? q[k][0] : '0;
                exp_rdy[k] = !rst && ((k == 1) ? (sz < 2) : (sz == 0 || out_ready));
                chk(k, "in_ready", rdy[k], exp_rdy[k]);
                chk(k, "out_valid", ov[k], sz > 0);
                chk(k, "occupancy", (k == 1) ? occ1 : occ0, sz);
                chk(k, "out_ctrl", (k == 1) ? oc1 : oc0, h[15:0]);
                if (sz > 0) chk(k, "out_data", (k == 1) ? od1 : od0, h[47:16]);
                chk(k, "stall_cycles", (k == 1) ? st1 : st0, exp_st[k]);
                stall_inc[k] = !rst && sz > 0 && !out_ready;
                if (!rst && out_ready && sz > 0) void'(q[k].pop_front());
            end
        end
    end

    initial begin
        logic [15:0] c;
        rst = 1'b1;
        repeat (3) cyc(0, 32'h0, 16'h0, 0, 0);
        chk(1, "reset_data", od1, 0);
        chk(0, "reset_data", od0, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            c = 16'($urandom) | 16'h1;
            cyc(1, 32'h100 + i, c, 1, 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'hA, 16'h00A1, 1, 0);
        cyc(1, 32'hB, 16'h00B2, 0, 0);
        cyc(1, 32'hC, 16'h00C3, 0, 0);
        chk(1, "held_two", occ1, 2);
        chk(1, "held_head", od1, 32'hA);
        repeat (2) cyc(1, 32'hC, 16'h00C3, 0, 0);
        repeat (3) cyc(1, 32'hC, 16'h00C3, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h51, 16'h5151, 0, 0);
        cyc(1, 32'h52, 16'h5252, 0, 0);
        cyc(1, 32'hDEAD, 16'hDEAD, 0, 1);
        chk(1, "flush_occ", occ1, 0);
        chk(1, "flush_ctrl", oc1, 0);
        chk(1, "flush_ready", rdy[1], 1);
        for (int i = 0; i < 32; i++) cyc(1, 32'h200 + i, 16'h0200 + 16'(i), i % 2 == 0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 32'h300 + i, 16'h0300 + 16'(i), 0, 0);
        repeat (20) cyc(0, 0, 0, 0, 0);
        chk(1, "stall_sat", st1, 15);
        chk(0, "stall_sat", st0, 15);
        rst = 1'b1;
        cyc(1, 32'h77, 16'h77, 0, 0);
        chk(1, "rst_data", od1, 0);
        chk(1, "rst_stall", st1, 0);
        chk(0, "rst_stall", st0, 0);
        rst = 1'b0;
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(3) != 0, $urandom, 16'($urandom), $urandom_range(2) != 0, $urandom_range(19) == 0);
        repeat (4) cyc(0, 0, 0, 1, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
